// File: rtl/reg_dump_pkg.sv
// Shared types for the register dump engine: FSM state encoding and address width.
// The CSUM state only exists when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

    localparam int ADDR_W = 5;

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/reg_dump_if.sv
// Bundle of the dump engine's control, register-bank read port and output stream.
// The master modport is the dump engine; the slave modport is the bank/downstream side.
interface reg_dump_if
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  start_i,
        input  rd_data_i,
        input  out_ready_i,
        output rd_addr_o,
        output out_valid_o,
        output out_data_o,
        output out_addr_o,
        output out_last_o,
        output busy_o,
        output done_o
    );

    modport slave (
        output start_i,
        output rd_data_i,
        output out_ready_i,
        input  rd_addr_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_addr_o,
        input  out_last_o,
        input  busy_o,
        input  done_o
    );

endinterface

// File: rtl/reg_dump.sv
// Walks registers 0..NUM_REGS-1 through a combinational read port and streams them out
// with a valid/ready handshake. REG_DUMP_CHECKSUM_EN appends an XOR checksum word.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | rd_addr_o = index, capture read data into the output register
// SEND  | word presented, waiting for out_ready_i
// CSUM  | checksum word presented (REG_DUMP_CHECKSUM_EN only)
// DONE  | one-cycle completion pulse
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input logic       clk,
    input logic       rst_n,
    reg_dump_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_last_q;
    logic              at_last;
    logic              xfer;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif

    assign at_last = (idx == LAST_IDX);
    assign xfer    = bus.out_valid_o && bus.out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start_i) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_SEND;
            ST_SEND: begin
                if (bus.out_ready_i) begin
                    if (!at_last) begin
                        state_nxt = ST_READ;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: if (bus.out_ready_i) state_nxt = ST_DONE;
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Index stays parked at LAST_IDX after the final word; it is only rewound on a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        idx        <= '0;
                        out_last_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    out_data_q <= bus.rd_data_i;
                    out_addr_q <= idx;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last_q <= 1'b0;
`else
                    out_last_q <= at_last;
`endif
                end
                ST_SEND: begin
                    if (bus.out_ready_i) begin
                        if (!at_last) begin
                            idx <= idx + 1'b1;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            out_data_q <= csum_q ^ out_data_q;
                            out_addr_q <= '0;
                            out_last_q <= 1'b1;
`else
                            out_last_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                ST_CSUM: if (bus.out_ready_i) out_last_q <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // Running XOR covers only words actually accepted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (state == ST_IDLE && bus.start_i) begin
            csum_q <= '0;
        end else if (state == ST_SEND && bus.out_ready_i) begin
            csum_q <= csum_q ^ out_data_q;
        end
    end
`endif

    assign bus.rd_addr_o = (state == ST_READ) ? idx : '0;
`ifdef REG_DUMP_CHECKSUM_EN
    assign bus.out_valid_o = (state == ST_SEND) || (state == ST_CSUM);
    assign bus.busy_o      = (state == ST_READ) || (state == ST_SEND) || (state == ST_CSUM);
`else
    assign bus.out_valid_o = (state == ST_SEND);
    assign bus.busy_o      = (state == ST_READ) || (state == ST_SEND);
`endif
    assign bus.done_o     = (state == ST_DONE);
    assign bus.out_data_o = out_data_q;
    assign bus.out_addr_o = out_addr_q;
    assign bus.out_last_o = out_last_q;

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter NUM_REGS, default 32, number of registers walked (addresses 0..NUM_REGS-1).
REQ-002 Parameter DATA_W, default 32, register word width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle request to begin a dump.
REQ-006 rd_addr_o  out  5  read address driven to a register-bank read port.
REQ-007 rd_data_i  in  DATA_W  combinational read data returned for rd_addr_o in the same cycle.
REQ-008 out_valid_o  out  1  output word valid.
REQ-009 out_ready_i  in  1  downstream accepts word.
REQ-010 out_data_o  out  DATA_W  dumped register contents.
REQ-011 out_addr_o  out  5  register index of out_data_o.
REQ-012 out_last_o  out  1  marks final word of the dump.
REQ-013 busy_o  out  1  high from the start acceptance until done_o.
REQ-014 done_o  out  1  single-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, READ, SEND, CSUM (CSUM only with the macro), DONE.
REQ-016 IDLE: rd_addr_o=0, out_valid_o=0; start_i=1 at an edge -> READ with index=0.
REQ-017 READ: rd_addr_o=index; at the edge, rd_data_i registered into out_data_o, index into out_addr_o -> SEND.
REQ-018 SEND: out_valid_o=1; out_data_o/out_addr_o/out_last_o stable while out_ready_i=0.
REQ-019 Handshake: a word transfers on an edge where out_valid_o=1 and out_ready_i=1; exactly one transfer per word.
REQ-020 After transfer in SEND: index<NUM_REGS-1 -> index+1, READ; index=NUM_REGS-1 -> CSUM if enabled, else DONE.
REQ-021 Latency: first out_valid_o high two edges after the edge sampling start_i; sustained throughput one word per 2 cycles with out_ready_i held high.
REQ-022 DONE: done_o=1 for exactly one cycle, busy_o=0 in that cycle, then IDLE.
REQ-023 start_i while busy_o=1 or in DONE is ignored; no queuing.
REQ-024 out_last_o=1 only on the final word: register NUM_REGS-1 without the macro, checksum word with it.
REQ-025 Index counter never wraps; it stops at NUM_REGS-1.
REQ-026 rd_addr_o value is never interpreted; register 0 content is forwarded as read, not forced.

Reset
REQ-027 rst_n low asynchronously forces IDLE, index=0, out_valid_o=0, out_last_o=0, busy_o=0, done_o=0, out_data_o=0, out_addr_o=0, checksum=0.
REQ-028 Reset mid-dump aborts it; no done_o pulse; next dump restarts at register 0.

Configuration
REQ-029 Macro REG_DUMP_CHECKSUM_EN defined: a running XOR of all transferred register words is kept, cleared on start acceptance, and sent from CSUM as one extra word with out_addr_o=0, out_last_o=1, same handshake rules, then DONE.
REQ-030 Macro undefined: no checksum register, no CSUM state; dump is exactly NUM_REGS words.

Structure
REQ-031 Package reg_dump_pkg holds the FSM state enumeration and the address-width constant (5).
REQ-032 Single flat module; no sub-module. Bench instantiates the register bank as the rd_addr_o/rd_data_i peer.

Verification
REQ-033 Reset, preload bank r1..r31 = 32'h100+i, pulse start_i, ready high -> 32 words, addr 0..31, data 0 then 32'h101..32'h11F, out_last_o on addr 31, done_o one pulse, first valid 2 edges after start.
REQ-034 Same preload, out_ready_i low 5 cycles on word addr 7 -> data 32'h107 and addr 7 held stable, no skipped or duplicated word.
REQ-035 start_i pulsed again at word 10 -> ignored; total still 32 words, one done_o.
REQ-036 rst_n low at word 15 -> out_valid_o falls immediately, no done_o; new start_i -> dump restarts at addr 0.
REQ-037 With REG_DUMP_CHECKSUM_EN, bank r1=32'hFFFF0000, r2=32'h0000FFFF, rest 0 -> 33rd word 32'hFFFFFFFF, out_addr_o=0, out_last_o=1; addr 31 word has out_last_o=0.
